// File: rtl/iot_pulse_sequencer.sv
// rtl/iot_pulse_sequencer.sv - PDP-8/I IOT sequencer: issues IOP1/IOP2/IOP4 on the
// negative I/O bus and merges the device skip, AC-clear and data returns.
module iot_pulse_sequencer #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int DATA_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iot_start,
  input  logic [2:0]        mb_bits,
  input  logic              io_skip,
  input  logic              io_ac_clr,
  input  logic [DATA_W-1:0] bus_in_n,
  output logic              busy,
  output logic              bus_en,
  output logic              iop1,
  output logic              iop2,
  output logic              iop4,
  output logic              done,
  output logic              skip,
  output logic              ac_clr,
  output logic [DATA_W-1:0] ac_or
);

  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P4,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       pend, pend_nxt;
  logic             sample;
  logic             clear_res;

  // pend holds the enabled pulses not yet issued; lowest set bit goes next
  function automatic state_t first_pulse(input logic [2:0] m);
    if (m[0])      return S_P1;
    else if (m[1]) return S_P2;
    else if (m[2]) return S_P4;
    else           return S_DONE;
  endfunction

  function automatic logic [2:0] drop_first(input logic [2:0] m);
    return m & (m - 3'd1);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    sample    = 1'b0;
    clear_res = 1'b0;
    case (state)
      S_IDLE: begin
        if (iot_start) begin
          clear_res = 1'b1;
          state_nxt = first_pulse(mb_bits);
          pend_nxt  = drop_first(mb_bits);
          cnt_nxt   = PULSE_LOAD;
        end
      end
      S_P1, S_P2, S_P4: begin
        if (cnt == '0) begin
          sample = 1'b1;
          if (pend == 3'b000) begin
            state_nxt = S_DONE;
          end else if (GAP_LEN == 0) begin
            state_nxt = first_pulse(pend);
            pend_nxt  = drop_first(pend);
            cnt_nxt   = PULSE_LOAD;
          end else begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LOAD;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_nxt = first_pulse(pend);
          pend_nxt  = drop_first(pend);
          cnt_nxt   = PULSE_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered decodes of the next state so they never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pend   <= 3'b000;
      busy   <= 1'b0;
      bus_en <= 1'b0;
      iop1   <= 1'b0;
      iop2   <= 1'b0;
      iop4   <= 1'b0;
      done   <= 1'b0;
      skip   <= 1'b0;
      ac_clr <= 1'b0;
      ac_or  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pend   <= pend_nxt;
      busy   <= (state_nxt != S_IDLE);
      bus_en <= (state_nxt inside {S_P1, S_P2, S_P4, S_GAP});
      iop1   <= (state_nxt == S_P1);
      iop2   <= (state_nxt == S_P2);
      iop4   <= (state_nxt == S_P4);
      done   <= (state_nxt == S_DONE);
      if (clear_res) begin
        skip   <= 1'b0;
        ac_clr <= 1'b0;
        ac_or  <= '0;
      end else if (sample) begin
        skip   <= skip | io_skip;
        ac_clr <= ac_clr | io_ac_clr;
        ac_or  <= ac_or | ~bus_in_n;
      end
    end
  end

endmodule

// File: tb/tb_iot_pulse_sequencer.sv
// tb/tb_iot_pulse_sequencer.sv - directed bench for iot_pulse_sequencer
// (PULSE_LEN=4, GAP_LEN=2, DATA_W=12).
module tb_iot_pulse_sequencer;

  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iot_start;
  logic [2:0]  mb_bits;
  logic        io_skip;
  logic        io_ac_clr;
  logic [11:0] bus_in_n;
  logic        busy, bus_en, iop1, iop2, iop4, done, skip, ac_clr;
  logic [11:0] ac_or;

  int n_chk  = 0;
  int n_pass = 0;

  iot_pulse_sequencer #(.PULSE_LEN(4), .GAP_LEN(2), .DATA_W(12)) dut (
    .clk(clk), .rst(rst), .iot_start(iot_start), .mb_bits(mb_bits),
    .io_skip(io_skip), .io_ac_clr(io_ac_clr), .bus_in_n(bus_in_n),
    .busy(busy), .bus_en(bus_en), .iop1(iop1), .iop2(iop2), .iop4(iop4),
    .done(done), .skip(skip), .ac_clr(ac_clr), .ac_or(ac_or)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // {busy, bus_en, iop1, iop2, iop4, done} at cycle T+k; pX=0 means pulse disabled
  function automatic logic [5:0] expv(input int k, input int p1, input int p2,
                                      input int p4, input int dk);
    int first;
    logic e1, e2, e4, eb, ee, ed;
    first = (p1 != 0) ? p1 : (p2 != 0) ? p2 : p4;
    e1 = (p1 != 0) && k >= p1 && k < p1 + PL;
    e2 = (p2 != 0) && k >= p2 && k < p2 + PL;
    e4 = (p4 != 0) && k >= p4 && k < p4 + PL;
    eb = k >= 1 && k <= dk;
    ee = (first != 0) && k >= first && k < dk;
    ed = (k == dk);
    return {eb, ee, e1, e2, e4, ed};
  endfunction

  // Entered and left at a falling edge; the start is driven in cycle T
  task automatic run_seq(input string name, input logic [2:0] mb,
                         input int p1, input int p2, input int p4, input int dk,
                         input int rst_k, input bit restart5,
                         input int ka, input logic [11:0] va,
                         input int kb, input logic [11:0] vb,
                         input int ks, input int kc);
    iot_start = 1'b1;
    mb_bits   = mb;
    io_skip   = 1'b0;
    io_ac_clr = 1'b0;
    bus_in_n  = 12'o7777;
    @(negedge clk);
    iot_start = 1'b0;
    mb_bits   = ~mb;
    for (int k = 1; k <= dk + 1; k++) begin
      if (rst_k > 0 && k == rst_k + 1) begin
        rst = 1'b0;
        check($sformatf("%s rst_outs", name),
              {busy, bus_en, iop1, iop2, iop4, done, skip, ac_clr, ac_or}, 32'h0);
        return;
      end
      check($sformatf("%s k=%0d", name, k),
            {busy, bus_en, iop1, iop2, iop4, done}, expv(k, p1, p2, p4, dk));
      bus_in_n  = (k == ka) ? va : (k == kb) ? vb : 12'o7777;
      io_skip   = (k == ks);
      io_ac_clr = (k == kc);
      iot_start = restart5 && (k == 5);
      mb_bits   = (restart5 && k == 5) ? 3'b111 : ~mb;
      if (k == rst_k) rst = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; iot_start = 1'b0; mb_bits = 3'b000;
    io_skip = 1'b0; io_ac_clr = 1'b0; bus_in_n = 12'o7777;
    repeat (2) @(negedge clk);
    check("reset_outs", {busy, bus_en, iop1, iop2, iop4, done, skip, ac_clr, ac_or}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // start coinciding with reset is dropped
    rst = 1'b1; iot_start = 1'b1; mb_bits = 3'b111;
    @(negedge clk);
    rst = 1'b0; iot_start = 1'b0;
    check("start_in_rst", {busy, iop1}, 32'h0);
    @(negedge clk);

    run_seq("t1_mb111", 3'b111, 1, 7, 13, 17, 0, 1'b0, 0, 12'o7777, 0, 12'o7777, 0, 0);
    check("t1_ac_or", ac_or, 32'h0);

    run_seq("t2_mb101", 3'b101, 1, 0, 7, 11, 0, 1'b0, 3, 12'o0000, 10, 12'o7776, 0, 4);
    check("t2_ac_or", ac_or, 32'(12'o0001));
    check("t2_ac_clr", ac_clr, 32'h1);
    check("t2_skip", skip, 32'h0);

    run_seq("t3_mb000", 3'b000, 0, 0, 0, 1, 0, 1'b0, 0, 12'o7777, 0, 12'o7777, 0, 0);
    check("t3_ac_clr_cleared", ac_clr, 32'h0);

    run_seq("t4_data", 3'b111, 1, 7, 13, 17, 0, 1'b0, 4, 12'o7770, 16, 12'o7707, 10, 0);
    check("t4_skip", skip, 32'h1);
    check("t4_ac_or", ac_or, 32'(12'o0077));
    check("t4_ac_clr", ac_clr, 32'h0);

    run_seq("t5_restart", 3'b111, 1, 7, 13, 17, 0, 1'b1, 0, 12'o7777, 0, 12'o7777, 0, 0);
    check("t5_skip_cleared", skip, 32'h0);

    run_seq("t6_reset", 3'b111, 1, 7, 13, 17, 8, 1'b0, 0, 12'o7777, 0, 12'o7777, 4, 0);
    @(negedge clk);
    run_seq("t6_after", 3'b101, 1, 0, 7, 11, 0, 1'b0, 0, 12'o7777, 0, 12'o7777, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
